// File: rtl/stack_unload.sv
// Stack drain engine: pops up to min(count, depth) words, top first, and
// streams each one out on a valid/ready interface.
module stack_unload #(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [saddr_width:0]   count,
    input  logic [saddr_width:0]   stk_depth,
    output logic                   busy,
    output logic                   done,
    output logic [width-1:0]       stk_d,
    output logic                   stk_dec,
    output logic                   stk_change,
    output logic                   stk_update,
    input  logic [width-1:0]       stk_q,
    output logic [width-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [saddr_width:0] REM_ONE = {{saddr_width{1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_next;
    logic [saddr_width:0] r_rem;
    logic [saddr_width:0] w_rem_next;
    logic [saddr_width:0] w_n;
    logic [width-1:0]     r_out_data;
    logic [width-1:0]     w_out_data_next;
    logic                 r_out_valid;
    logic                 w_out_valid_next;
    logic                 w_hs;
    logic                 w_pop;

    // Clamp the request to the live depth so no pop ever runs past empty.
    assign w_n  = (count < stk_depth) ? count : stk_depth;
    assign w_hs = r_out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_rem_next       = r_rem;
        w_out_data_next  = r_out_data;
        w_out_valid_next = r_out_valid;
        w_pop            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_n != '0) begin
                        w_state_next = S_LOAD;
                        w_rem_next   = w_n;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                w_out_data_next  = stk_q;
                w_out_valid_next = 1'b1;
                w_pop            = 1'b1;
                w_state_next     = S_SEND;
            end
            S_SEND: begin
                // Pop and capture happen together: the popped word shows on
                // stk_q next cycle, exactly when the next capture is due.
                if (w_hs) begin
                    if (r_rem > REM_ONE) begin
                        w_out_data_next = stk_q;
                        w_rem_next      = r_rem - REM_ONE;
                        w_pop           = 1'b1;
                    end else begin
                        w_out_valid_next = 1'b0;
                        w_rem_next       = '0;
                        w_state_next     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rem       <= w_rem_next;
            r_out_data  <= w_out_data_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign busy       = (r_state == S_LOAD) || (r_state == S_SEND);
    assign done       = (r_state == S_DONE);
    assign stk_change = w_pop;
    assign stk_dec    = w_pop;
    assign stk_d      = '0;
    assign stk_update = 1'b0;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_stack_unload.sv
// Bench for stack_unload: a behavioural stack feeds stk_q, and a word
// queue model predicts emitted data, pops, busy/valid and done timing.
module tb_stack_unload;

    localparam int SAW  = 8;
    localparam int W    = 16;
    localparam int MEM  = 512;
    localparam int MAXC = 2000;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [SAW:0]   count;
    logic [SAW:0]   stk_depth;
    logic           busy;
    logic           done;
    logic [W-1:0]   stk_d;
    logic           stk_dec;
    logic           stk_change;
    logic           stk_update;
    logic [W-1:0]   stk_q;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stack_unload #(
        .saddr_width(SAW),
        .width(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .count(count),
        .stk_depth(stk_depth),
        .busy(busy),
        .done(done),
        .stk_d(stk_d),
        .stk_dec(stk_dec),
        .stk_change(stk_change),
        .stk_update(stk_update),
        .stk_q(stk_q),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Stack model: depth = sp_base - pops_total; top word is mem[depth-1].
    logic [W-1:0] mem [MEM];
    int sp_base    = 0;
    int pops_total = 0;
    int underflow  = 0;

    always_comb begin
        stk_q = '0;
        if (sp_base > pops_total) stk_q = mem[9'(sp_base - pops_total - 1)];
    end

    always @(posedge clk) begin
        if (stk_change === 1'b1) begin
            if (sp_base <= pops_total) underflow <= underflow + 1;
            else                       pops_total <= pops_total + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One unload command from start through the cycle after done.
    task automatic run_op(input int cnt, input int dep, input bit keep,
                          input logic [W-1:0] base, input bit rnd_ready,
                          input logic [15:0] pat, input int plen,
                          input int exp_lat, input int restart_at);
        int n, c, acc_last, pops0;
        bit got_done, prev_stall, hs_m, pop_m, done_m;
        logic [W-1:0] prev_data;
        logic [W-1:0] expq[$];

        if (keep) begin
            dep = sp_base - pops_total;
        end else begin
            for (int i = 0; i < dep; i++)
                mem[i] = (base == '0) ? W'($urandom) : W'(base * (i + 1));
            sp_base = pops_total + dep;
        end
        n = (cnt < dep) ? cnt : dep;
        for (int j = 0; j < n; j++) expq.push_back(mem[dep - 1 - j]);
        pops0 = pops_total;

        @(negedge clk);
        start     = 1'b1;
        count     = 9'(cnt);
        stk_depth = 9'(dep);
        out_ready = 1'b1;
        c = 0; acc_last = -1; got_done = 0; prev_stall = 0; prev_data = '0;

        while (!got_done && c < MAXC) begin
            @(negedge clk);
            c++;
            start = (c == restart_at);
            if (start) begin
                count     = 9'd1;
                stk_depth = 9'(sp_base - pops_total);
            end
            if (rnd_ready)                    out_ready = ($urandom_range(0, 99) < 60);
            else if (c >= 2 && c - 2 < plen) out_ready = pat[c - 2];
            else                              out_ready = 1'b1;
            #1;
            if (prev_stall) begin
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_valid", 32'(out_valid), 32'd1);
            end
            hs_m   = (c >= 2) && (expq.size() > 0) && out_ready;
            pop_m  = (n > 0 && c == 1) || (hs_m && expq.size() > 1);
            done_m = (n == 0) ? (c == 1) : (acc_last >= 0 && c == acc_last + 1);
            chk("valid", 32'(out_valid), 32'((c >= 2) && (expq.size() > 0)));
            chk("busy", 32'(busy), 32'(expq.size() > 0));
            chk("done", 32'(done), 32'(done_m));
            chk("stk_change", 32'(stk_change), 32'(pop_m));
            chk("stk_dec", 32'(stk_dec), 32'(pop_m));
            if (hs_m) begin
                chk("word", 32'(out_data), 32'(expq.pop_front()));
                if (expq.size() == 0) acc_last = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) got_done = 1;
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("words_left", 32'(expq.size()), 32'd0);
        if (exp_lat > 0) chk("done_lat", 32'(c), 32'(exp_lat));
        chk("pops", 32'(pops_total - pops0), 32'(n));
        chk("underflow", 32'(underflow), 32'd0);
        chk("stk_d", 32'(stk_d), 32'd0);
        chk("stk_update", 32'(stk_update), 32'd0);

        // A start landing on the done cycle must be ignored.
        start     = 1'b1;
        count     = 9'd3;
        stk_depth = 9'(sp_base - pops_total);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_change", 32'(stk_change), 32'd0);
    endtask

    typedef struct {
        int          cnt;
        int          dep;
        logic [15:0] base;
        logic [15:0] pat;
        int          plen;
        int          lat;
        int          restart_at;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int pops0, rs, rdep, rcnt;

        tbl[0] = '{cnt: 3,   dep: 3,   base: 16'h1111, pat: 16'h0,  plen: 0, lat: 5,   restart_at: 0};
        tbl[1] = '{cnt: 5,   dep: 2,   base: 16'h5555, pat: 16'h0,  plen: 0, lat: 4,   restart_at: 0};
        tbl[2] = '{cnt: 0,   dep: 3,   base: 16'h0,    pat: 16'h0,  plen: 0, lat: 1,   restart_at: 0};
        tbl[3] = '{cnt: 4,   dep: 0,   base: 16'h0,    pat: 16'h0,  plen: 0, lat: 1,   restart_at: 0};
        tbl[4] = '{cnt: 4,   dep: 4,   base: 16'h0,    pat: 16'h69, plen: 7, lat: 9,   restart_at: 0};
        tbl[5] = '{cnt: 1,   dep: 1,   base: 16'h0,    pat: 16'h0,  plen: 0, lat: 3,   restart_at: 0};
        tbl[6] = '{cnt: 511, dep: 300, base: 16'h0,    pat: 16'h0,  plen: 0, lat: 302, restart_at: 0};
        tbl[7] = '{cnt: 5,   dep: 6,   base: 16'h0,    pat: 16'h0,  plen: 0, lat: 7,   restart_at: 4};

        reset = 1'b1; start = 1'b0; count = '0; stk_depth = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_change", 32'(stk_change), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].cnt, tbl[i].dep, 1'b0, tbl[i].base, 1'b0,
                   tbl[i].pat, tbl[i].plen, tbl[i].lat, tbl[i].restart_at);

        // Reset after two accepted words: three pops issued (LOAD + two sends).
        for (int i = 0; i < 4; i++) mem[i] = W'(16'hA001 + i);
        sp_base = pops_total + 4;
        pops0   = pops_total;
        @(negedge clk);
        start = 1'b1; count = 9'd4; stk_depth = 9'd4; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 chk("rr_word0", 32'(out_data), 32'h0000A004);
        @(negedge clk);
        #1 chk("rr_word1", 32'(out_data), 32'h0000A003);
        @(negedge clk);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rr_valid", 32'(out_valid), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_change", 32'(stk_change), 32'd0);
        chk("rr_pops", 32'(pops_total - pops0), 32'd3);
        run_op(1, 0, 1'b1, 16'h0, 1'b0, 16'h0, 0, 3, 0);

        for (int k = 0; k < 25; k++) begin
            rdep = $urandom_range(0, 20);
            rcnt = $urandom_range(0, 24);
            rs   = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 8) : 0;
            run_op(rcnt, rdep, 1'b0, 16'h0, 1'b1, 16'h0, 0, 0, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
